array_unpack_serializer: RTL and testbench
==========================================

Name: array_unpack_serializer

Overview:
- Reads an unpacked array frame and emits its elements one per beat on a scalar valid/ready stream.
- It is the reader/unpacking end of the array-building logic: element-wise `array_get` instead of `array_create`, run sequentially.
- Used as an rtl2rtl equivalence case for unpacked-array registers, indexed reads and handshake FSMs.
- Sits between a block producing `logic [ELEM_W-1:0] arr [DEPTH-1:0]` and a narrow consumer.

Parameters:
- ELEM_W, 8, width of one array element in bits (>=1).
- DEPTH, 4, number of elements per frame (>=1).
- IDX_W, $clog2(DEPTH) with a minimum of 1, localparam, width of the element index.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input frame valid.
- in_ready  out  1  block can accept a frame.
- in_arr  in  ELEM_W x [DEPTH-1:0] unpacked  input frame; element i = in_arr[i].
- out_valid  out  1  output element valid.
- out_ready  in  1  consumer accepts element.
- out_data  out  ELEM_W  current element.
- out_idx  out  IDX_W  array index of out_data.
- out_last  out  1  high with the final element of a frame.
- busy  out  1  frame held (state SEND).

Behaviour:
- Storage: internal unpacked register buf[DEPTH-1:0] of ELEM_W bits.
- Storage: index counter idx (IDX_W bits).
- FSM states: IDLE and SEND.
- Reset (rst_n low, asynchronous):
  - state=IDLE, idx=0, every buf element=0.
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, in_ready=1 (after reset).
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture all of in_arr into buf in one cycle, set idx to the first index, go to SEND.
- SEND:
  - out_valid=1, out_data=buf[idx], out_idx=idx, busy=1.
  - out_last=1 when idx equals the last index.
- Beat transfer = out_valid&&out_ready:
  - Not last: idx advances by one.
  - Last: go to IDLE.
- Stall: while out_valid&&!out_ready, out_data, out_idx and out_last hold stable.
- Back-to-back frames:
  - in_ready = (state==IDLE) || (out_last && out_ready). This is combinational from out_ready.
  - If a new frame is accepted on the last beat, buf is reloaded, idx is set to the first index, and the FSM stays in SEND.
  - Result: no bubble between frames.
- Latency: first element is valid on the cycle after frame acceptance. A frame takes DEPTH beats with no stalls.
- Input isolation: in_arr changes after capture do not affect the frame in flight.
- No wrap-around past the last index: idx is reloaded only on frame acceptance.
- DEPTH==1: every frame is a single beat with out_last=1 and out_idx=0.
- Reset mid-frame: the frame is dropped and out_valid falls immediately (asynchronously).
- Simultaneous events: in_valid is ignored unless in_ready is high. A frame is never overwritten before its last beat.

Optional Feature:
- Macro: ARRAY_UNPACK_SER_REVERSE_EN.
- Defined:
  - Elements are emitted highest index first: DEPTH-1 down to 0.
  - idx loads DEPTH-1 on acceptance and decrements.
  - out_last=1 when idx==0.
- Not defined:
  - Ascending order 0..DEPTH-1.
  - idx loads 0 on acceptance.
  - out_last=1 when idx==DEPTH-1.
- Port list is identical in both builds.

Test Plan:
- Reset and idle: hold rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, busy=0, out_data=0.
- Basic frame: in_arr='{8'h44,8'h33,8'h22,8'h11} (index3..0), in_valid one cycle, out_ready=1 -> starting the next cycle, out_data 11,22,33,44 with out_idx 0..3; out_last only on 44; then IDLE.
- Backpressure: same frame with out_ready=0 for 5 cycles on beat 2 -> out_data=22 and out_idx=1 held stable; remaining beats unchanged; in_arr changed to all 8'hFF during the stall does not appear at the output.
- Back-to-back: second frame '{8'hD4,8'hC3,8'hB2,8'hA1} presented with in_valid held -> accepted on the cycle of beat 44; A1 follows 44 with no idle cycle; 8 beats over 8 consecutive cycles.
- Mid-frame reset: assert rst_n=0 after beat 2 -> out_valid=0 at once; after release, a new frame '{8'h04,8'h03,8'h02,8'h01} emits from index 0 with correct data.
- Reverse build (ARRAY_UNPACK_SER_REVERSE_EN, DEPTH=4) with the basic frame -> output 44,33,22,11, out_idx 3..0, out_last on 11. Also DEPTH=1 build: every beat has out_last=1.

Source files
------------

// File: rtl/array_unpack_serializer_if.sv
// Frame-in / element-out handshake bundle for array_unpack_serializer.
// The slave modport is the serializer's view; master is the surrounding producer/consumer.
interface array_unpack_serializer_if #(
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 4
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [ELEM_W-1:0] in_arr [DEPTH-1:0];
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;

  modport slave (
    input  in_valid, in_arr, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_arr, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, busy
  );
endinterface

// File: rtl/array_unpack_serializer.sv
// Captures a whole unpacked-array frame and emits it one element per valid/ready beat.
// Define ARRAY_UNPACK_SER_REVERSE_EN to emit elements highest index first.
module array_unpack_serializer #(
  parameter int ELEM_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  array_unpack_serializer_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef ARRAY_UNPACK_SER_REVERSE_EN
  localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_IDX = '0;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
`endif

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state_q;
  logic [ELEM_W-1:0] frameBuf_q [DEPTH-1:0];
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [ELEM_W-1:0] outData_q;
  logic              outLast_q;
  logic              accept;
  logic              beat;

  // A new frame may land on the last beat of the current one, giving gapless frames.
  assign bus.in_ready = (state_q == IDLE) || (outLast_q && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign beat         = (state_q == SEND) && bus.out_ready;

  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.out_data  = outData_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = outLast_q;

  // Never step past the last index, so the buffer read below stays in range.
  always_comb begin
    idx_d = idx_q;
    if (idx_q != LAST_IDX) begin
`ifdef ARRAY_UNPACK_SER_REVERSE_EN
      idx_d = idx_q - IDX_W'(1);
`else
      idx_d = idx_q + IDX_W'(1);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      outData_q <= '0;
      outLast_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        frameBuf_q[i] <= '0;
      end
    end else if (accept) begin
      state_q    <= SEND;
      frameBuf_q <= bus.in_arr;
      idx_q      <= FIRST_IDX;
      outData_q  <= bus.in_arr[FIRST_IDX];
      outLast_q  <= (FIRST_IDX == LAST_IDX);
    end else if (beat) begin
      if (outLast_q) begin
        state_q   <= IDLE;
        outLast_q <= 1'b0;
      end else begin
        idx_q     <= idx_d;
        outData_q <= frameBuf_q[idx_d];
        outLast_q <= (idx_d == LAST_IDX);
      end
    end
  end
endmodule

// File: tb/tb_array_unpack_serializer.sv
// Directed plus random stimulus for array_unpack_serializer, checked against a queue-based
// model of the element stream. Honours ARRAY_UNPACK_SER_REVERSE_EN; TB_DEPTH_ONE selects DEPTH=1.
`timescale 1ns/1ps
module tb_array_unpack_serializer;
  localparam int ELEM_W = 8;
`ifdef TB_DEPTH_ONE
  localparam int DEPTH = 1;
`else
  localparam int DEPTH = 4;
`endif
`ifdef ARRAY_UNPACK_SER_REVERSE_EN
  localparam bit REVERSE = 1'b1;
`else
  localparam bit REVERSE = 1'b0;
`endif

  typedef struct {
    logic [ELEM_W-1:0] data;
    int                idx;
    bit                last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  beat_t             model[$];
  bit                acceptExp;
  logic [ELEM_W-1:0] frame [DEPTH-1:0];

  array_unpack_serializer_if #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) bus ();

  array_unpack_serializer #(.ELEM_W(ELEM_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.in_arr = frame;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit inValid, input bit outReady);
    bus.in_valid  = inValid;
    bus.out_ready = outReady;
  endtask

  // Element i of the frame is byte i of w (low byte = index 0).
  task automatic loadFrame(input logic [31:0] w);
    for (int i = 0; i < DEPTH; i++) begin
      frame[i] = (i < 4) ? w[8*i +: 8] : '0;
    end
  endtask

  task automatic checkOutput();
    bit expValid;
    bit expReady;
    expValid = (model.size() > 0);
    expReady = (model.size() == 0) || (model.size() == 1 && bus.out_ready);
    checkEq("out_valid", 32'(bus.out_valid), 32'(expValid));
    checkEq("in_ready",  32'(bus.in_ready),  32'(expReady));
    checkEq("busy",      32'(bus.busy),      32'(expValid));
    if (expValid) begin
      checkEq("out_data", 32'(bus.out_data), 32'(model[0].data));
      checkEq("out_idx",  32'(bus.out_idx),  32'(model[0].idx));
      checkEq("out_last", 32'(bus.out_last), 32'(model[0].last));
    end
  endtask

  // Model: the queue holds the not-yet-transferred elements of the frame in flight.
  task automatic updateModel();
    beat_t b;
    int    i;
    if (!rst_n) begin
      model.delete();
      acceptExp = 1'b0;
      return;
    end
    acceptExp = bus.in_valid && ((model.size() == 0) || (model.size() == 1 && bus.out_ready));
    if (model.size() > 0 && bus.out_ready) begin
      void'(model.pop_front());
    end
    if (acceptExp) begin
      for (int k = 0; k < DEPTH; k++) begin
        i      = REVERSE ? (DEPTH - 1 - k) : k;
        b.data = frame[i];
        b.idx  = i;
        b.last = (k == DEPTH - 1);
        model.push_back(b);
      end
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    updateModel();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    rst_n = 1'b0;
    acceptExp = 1'b0;
    applyStimulus(1'b0, 1'b1);
    loadFrame(32'h0);
    repeat (3) stepCycle();
    checkEq("reset_out_data", 32'(bus.out_data), 32'h0);
    checkEq("reset_out_idx",  32'(bus.out_idx),  32'h0);
    checkEq("reset_out_last", 32'(bus.out_last), 32'h0);
    rst_n = 1'b1;
    stepCycle();
    checkEq("idle_out_data", 32'(bus.out_data), 32'h0);

    // Basic frame
    $display("[TB] basic frame");
    loadFrame(32'h44332211);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (DEPTH + 1) stepCycle();

    // Backpressure on beat 2, with the input frame scribbled during the stall
    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b0);
    loadFrame(32'hFFFFFFFF);
    repeat (5) stepCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (DEPTH + 1) stepCycle();

    // Back-to-back frames with in_valid held until the second is taken
    $display("[TB] back-to-back");
    loadFrame(32'h44332211);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    loadFrame(32'hD4C3B2A1);
    for (int c = 0; c < 3 * DEPTH && bus.in_valid; c++) begin
      stepCycle();
      if (acceptExp) bus.in_valid = 1'b0;
    end
    applyStimulus(1'b0, 1'b1);
    repeat (DEPTH + 1) stepCycle();

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    loadFrame(32'h44332211);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (2) stepCycle();
    rst_n = 1'b0;
    #1;
    checkEq("midrst_out_valid", 32'(bus.out_valid), 32'h0);
    checkEq("midrst_busy",      32'(bus.busy),      32'h0);
    checkEq("midrst_in_ready",  32'(bus.in_ready),  32'h1);
    model.delete();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    stepCycle();
    loadFrame(32'h04030201);
    applyStimulus(1'b1, 1'b1);
    stepCycle();
    applyStimulus(1'b0, 1'b1);
    repeat (DEPTH + 1) stepCycle();

    // Random traffic on both sides
    $display("[TB] random traffic");
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < DEPTH; i++) frame[i] = ELEM_W'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      stepCycle();
    end
    applyStimulus(1'b0, 1'b1);
    repeat (DEPTH + 2) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
